// File: rtl/icache_nway.sv
// icache_nway: set-associative instruction cache with per-set round-robin
// replacement, a valid/ready line-fill port and a whole-cache flush.
module icache_nway #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned SETS       = 8,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid_i,
    input  logic [ADDR_W-1:0]        req_addr_i,
    output logic                     req_ready_o,
    output logic                     rsp_valid_o,
    output logic [31:0]              rsp_inst_o,
    output logic                     busy_o,
    input  logic                     flush_i,
    output logic                     mem_req_valid_o,
    output logic [ADDR_W-1:0]        mem_req_addr_o,
    input  logic                     mem_req_ready_i,
    input  logic                     mem_rvalid_i,
    input  logic [32*LINE_WORDS-1:0] mem_rdata_i
);

    localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned LOW_W  = OFF_W + 2;
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - LOW_W;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned LINE_W = 32 * LINE_WORDS;

    typedef enum logic [1:0] {IDLE, MISS_REQ, REFILL, FLUSH} state_t;

    state_t state_q, state_d;

    // Tag/valid/data storage and per-set replacement pointers
    logic              valid_q [WAYS][SETS];
    logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
    logic [LINE_W-1:0] data_q  [WAYS][SETS];
    logic [WAY_W-1:0]  ptr_q   [SETS];

    // Outstanding miss context
    logic [TAG_W-1:0]  miss_tag_q;
    logic [IDX_W-1:0]  miss_idx_q;
    logic [OFF_W-1:0]  miss_off_q;
    logic [WAY_W-1:0]  victim_q;
    logic              victim_full_q;
    logic              flush_pend_q, flush_pend_d;

    logic              rsp_valid_d;
    logic [31:0]       rsp_inst_d;
    logic              busy_d;
    logic              mem_req_valid_d;
    logic [ADDR_W-1:0] mem_req_addr_d;

    logic              miss_load_c;
    logic              fill_we_c;
    logic              flush_clr_c;

    logic [TAG_W-1:0]  req_tag_c;
    logic [IDX_W-1:0]  req_idx_c;
    logic [OFF_W-1:0]  req_off_c;
    logic              hit_c;
    logic [31:0]       hit_word_c;
    logic [WAY_W-1:0]  victim_c;
    logic              set_full_c;
    logic [WAY_W-1:0]  ptr_next_c;

    logic [1:0]        unused_addr_lsb;

    assign req_tag_c       = req_addr_i[ADDR_W-1 -: TAG_W];
    assign req_idx_c       = req_addr_i[LOW_W +: IDX_W];
    assign req_off_c       = req_addr_i[2 +: OFF_W];
    assign unused_addr_lsb = req_addr_i[1:0];

    assign req_ready_o = (state_q == IDLE) && !flush_i && !flush_pend_q;

    // Tag compare across the indexed set and victim choice (lowest invalid way, else pointer)
    always_comb begin
        logic invalid_seen;
        hit_c        = 1'b0;
        hit_word_c   = '0;
        victim_c     = ptr_q[req_idx_c];
        set_full_c   = 1'b1;
        invalid_seen = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][req_idx_c] && (tag_q[w][req_idx_c] == req_tag_c)) begin
                hit_c      = 1'b1;
                hit_word_c = data_q[w][req_idx_c][{req_off_c, 5'b0} +: 32];
            end
            if (!valid_q[w][req_idx_c]) begin
                set_full_c = 1'b0;
                if (!invalid_seen) begin
                    victim_c     = WAY_W'(w);
                    invalid_seen = 1'b1;
                end
            end
        end
    end

    // Round-robin advance; a direct-mapped cache keeps its pointer at zero
    always_comb begin
        ptr_next_c = '0;
        if (WAYS > 1) begin
            ptr_next_c = WAY_W'(ptr_q[miss_idx_q] + 1'b1);
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d         = state_q;
        flush_pend_d    = flush_pend_q;
        rsp_valid_d     = 1'b0;
        rsp_inst_d      = rsp_inst_o;
        mem_req_valid_d = mem_req_valid_o;
        mem_req_addr_d  = mem_req_addr_o;
        miss_load_c     = 1'b0;
        fill_we_c       = 1'b0;
        flush_clr_c     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d = FLUSH;
                end else if (req_valid_i) begin
                    if (hit_c) begin
                        rsp_valid_d = 1'b1;
                        rsp_inst_d  = hit_word_c;
                    end else begin
                        state_d         = MISS_REQ;
                        miss_load_c     = 1'b1;
                        mem_req_valid_d = 1'b1;
                        mem_req_addr_d  = {req_addr_i[ADDR_W-1:LOW_W], LOW_W'(0)};
                    end
                end
            end
            MISS_REQ: begin
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_req_ready_i) begin
                    state_d         = REFILL;
                    mem_req_valid_d = 1'b0;
                end
            end
            REFILL: begin
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_rvalid_i) begin
                    fill_we_c   = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_inst_d  = mem_rdata_i[{miss_off_q, 5'b0} +: 32];
                    if (flush_i || flush_pend_q) begin
                        state_d      = FLUSH;
                        flush_pend_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FLUSH: begin
                flush_clr_c = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            flush_pend_q    <= 1'b0;
            rsp_valid_o     <= 1'b0;
            rsp_inst_o      <= '0;
            busy_o          <= 1'b0;
            mem_req_valid_o <= 1'b0;
            mem_req_addr_o  <= '0;
        end else begin
            state_q         <= state_d;
            flush_pend_q    <= flush_pend_d;
            rsp_valid_o     <= rsp_valid_d;
            rsp_inst_o      <= rsp_inst_d;
            busy_o          <= busy_d;
            mem_req_valid_o <= mem_req_valid_d;
            mem_req_addr_o  <= mem_req_addr_d;
        end
    end

    // Capture miss context at the accepting edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_tag_q    <= '0;
            miss_idx_q    <= '0;
            miss_off_q    <= '0;
            victim_q      <= '0;
            victim_full_q <= 1'b0;
        end else if (miss_load_c) begin
            miss_tag_q    <= req_tag_c;
            miss_idx_q    <= req_idx_c;
            miss_off_q    <= req_off_c;
            victim_q      <= victim_c;
            victim_full_q <= set_full_c;
        end
    end

    // Valid bits and replacement pointers: cleared on reset/flush, updated on fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                end
            end
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
            end
        end else if (flush_clr_c) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                end
            end
            for (int s = 0; s < SETS; s++) begin
                ptr_q[s] <= '0;
            end
        end else if (fill_we_c) begin
            valid_q[victim_q][miss_idx_q] <= 1'b1;
            if (victim_full_q) begin
                ptr_q[miss_idx_q] <= ptr_next_c;
            end
        end
    end

    // Line data and tags are only meaningful under a set valid bit, so they carry no reset
    always_ff @(posedge clk) begin
        if (fill_we_c) begin
            data_q[victim_q][miss_idx_q] <= mem_rdata_i;
            tag_q[victim_q][miss_idx_q]  <= miss_tag_q;
        end
    end

endmodule

// File: tb/tb_icache_nway.sv
// tb_icache_nway: directed tests for icache_nway in its default configuration
// (32-bit address, 8 sets, 2 ways, 4-word lines). Fill word at byte address A
// carries the value 32'hC0DE_0000 ^ A.
module tb_icache_nway;

    logic         clk;
    logic         rst_n;
    logic         req_valid_i;
    logic [31:0]  req_addr_i;
    logic         req_ready_o;
    logic         rsp_valid_o;
    logic [31:0]  rsp_inst_o;
    logic         busy_o;
    logic         flush_i;
    logic         mem_req_valid_o;
    logic [31:0]  mem_req_addr_o;
    logic         mem_req_ready_i;
    logic         mem_rvalid_i;
    logic [127:0] mem_rdata_i;

    int errors;
    int checks;

    icache_nway #(
        .ADDR_W(32), .SETS(8), .WAYS(2), .LINE_WORDS(4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid_i     (req_valid_i),
        .req_addr_i      (req_addr_i),
        .req_ready_o     (req_ready_o),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_inst_o      (rsp_inst_o),
        .busy_o          (busy_o),
        .flush_i         (flush_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_rvalid_i    (mem_rvalid_i),
        .mem_rdata_i     (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] mk_line(input logic [31:0] base);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) begin
            l[32*k +: 32] = 32'hC0DE_0000 ^ (base + 32'(4*k));
        end
        return l;
    endfunction

    // Advance one clock and settle just past the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        step();
        req_valid_i = 1'b0;
    endtask

    task automatic grant();
        mem_req_ready_i = 1'b1;
        step();
        mem_req_ready_i = 1'b0;
    endtask

    task automatic fill(input logic [31:0] base);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mk_line(base);
        step();
        mem_rvalid_i = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready_o); end
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_o); end
        checks++; if (rsp_inst_o !== 32'h0) begin errors++; $display("FAIL reset_rsp_inst: got %h want 0", rsp_inst_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid: got %b want 0", mem_req_valid_o); end
        checks++; if (mem_req_addr_o !== 32'h0) begin errors++; $display("FAIL reset_mem_req_addr: got %h want 0", mem_req_addr_o); end
    endtask

    task automatic test_cold_miss();
        issue(32'h0000_0104);
        checks++; if (mem_req_valid_o !== 1'b1) begin errors++; $display("FAIL cold_mem_req_valid: got %b want 1", mem_req_valid_o); end
        checks++; if (mem_req_addr_o !== 32'h0000_0100) begin errors++; $display("FAIL cold_mem_req_addr: got %h want 00000100", mem_req_addr_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL cold_busy_req: got %b want 1", busy_o); end
        checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL cold_req_ready_miss: got %b want 0", req_ready_o); end
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL cold_rsp_early: got %b want 0", rsp_valid_o); end
        grant();
        checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL cold_mem_req_drop: got %b want 0", mem_req_valid_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL cold_busy_refill: got %b want 1", busy_o); end
        fill(32'h0000_0100);
        checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL cold_rsp_valid: got %b want 1", rsp_valid_o); end
        checks++; if (rsp_inst_o !== 32'hC0DE_0104) begin errors++; $display("FAIL cold_rsp_inst: got %h want C0DE0104", rsp_inst_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL cold_busy_done: got %b want 0", busy_o); end
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL cold_req_ready_done: got %b want 1", req_ready_o); end
        issue(32'h0000_0108);
        checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL hit_rsp_valid: got %b want 1", rsp_valid_o); end
        checks++; if (rsp_inst_o !== 32'hC0DE_0108) begin errors++; $display("FAIL hit_rsp_inst: got %h want C0DE0108", rsp_inst_o); end
        checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL hit_no_mem_req: got %b want 0", mem_req_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL hit_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_streaming();
        logic [31:0] exp_inst;
        req_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_addr_i = 32'h0000_0100 + 32'(4*i);
            exp_inst   = 32'hC0DE_0100 + 32'(4*i);
            checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b want 1", i, req_ready_o); end
            step();
            checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL stream_rsp_valid[%0d]: got %b want 1", i, rsp_valid_o); end
            checks++; if (rsp_inst_o !== exp_inst) begin errors++; $display("FAIL stream_rsp_inst[%0d]: got %h want %h", i, rsp_inst_o, exp_inst); end
        end
        req_valid_i = 1'b0;
        step();
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL stream_idle_rsp: got %b want 0", rsp_valid_o); end
    endtask

    task automatic test_conflict();
        apply_reset();
        issue(32'h0000_0000); grant(); fill(32'h0000_0000);
        issue(32'h0000_0080); grant(); fill(32'h0000_0080);
        checks++; if (rsp_inst_o !== 32'hC0DE_0080) begin errors++; $display("FAIL conf_fill080: got %h want C0DE0080", rsp_inst_o); end
        issue(32'h0000_0100);
        checks++; if (mem_req_valid_o !== 1'b1) begin errors++; $display("FAIL conf_miss100: got %b want 1", mem_req_valid_o); end
        grant(); fill(32'h0000_0100);
        issue(32'h0000_0080);
        checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL conf_hit080_valid: got %b want 1", rsp_valid_o); end
        checks++; if (rsp_inst_o !== 32'hC0DE_0080) begin errors++; $display("FAIL conf_hit080_inst: got %h want C0DE0080", rsp_inst_o); end
        issue(32'h0000_0000);
        checks++; if (mem_req_valid_o !== 1'b1) begin errors++; $display("FAIL conf_miss000: got %b want 1", mem_req_valid_o); end
        checks++; if (mem_req_addr_o !== 32'h0) begin errors++; $display("FAIL conf_miss000_addr: got %h want 0", mem_req_addr_o); end
        grant(); fill(32'h0000_0000);
        checks++; if (rsp_inst_o !== 32'hC0DE_0000) begin errors++; $display("FAIL conf_fill000: got %h want C0DE0000", rsp_inst_o); end
        issue(32'h0000_010C);
        checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL conf_hit100_valid: got %b want 1", rsp_valid_o); end
        checks++; if (rsp_inst_o !== 32'hC0DE_010C) begin errors++; $display("FAIL conf_hit100_inst: got %h want C0DE010C", rsp_inst_o); end
        issue(32'h0000_0080);
        checks++; if (mem_req_valid_o !== 1'b1) begin errors++; $display("FAIL conf_evicted080: got %b want 1", mem_req_valid_o); end
        grant(); fill(32'h0000_0080);
    endtask

    task automatic test_backpressure();
        issue(32'h0000_03F8);
        for (int i = 0; i < 5; i++) begin
            checks++; if (mem_req_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, mem_req_valid_o); end
            checks++; if (mem_req_addr_o !== 32'h0000_03F0) begin errors++; $display("FAIL bp_addr[%0d]: got %h want 000003F0", i, mem_req_addr_o); end
            checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL bp_busy[%0d]: got %b want 1", i, busy_o); end
            checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL bp_rsp[%0d]: got %b want 0", i, rsp_valid_o); end
            step();
        end
        grant(); fill(32'h0000_03F0);
        checks++; if (rsp_inst_o !== 32'hC0DE_03F8) begin errors++; $display("FAIL bp_rsp_inst: got %h want C0DE03F8", rsp_inst_o); end
    endtask

    task automatic test_flush_idle();
        flush_i     = 1'b1;
        req_valid_i = 1'b1;
        req_addr_i  = 32'h0000_03F8;
        #1;
        checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL fli_ready_comb: got %b want 0", req_ready_o); end
        step();
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL fli_no_rsp: got %b want 0", rsp_valid_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL fli_busy: got %b want 1", busy_o); end
        checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL fli_ready_flush: got %b want 0", req_ready_o); end
        checks++; if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL fli_no_mem: got %b want 0", mem_req_valid_o); end
        step();
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL fli_ready_back: got %b want 1", req_ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL fli_busy_done: got %b want 0", busy_o); end
        issue(32'h0000_03F8);
        checks++; if (mem_req_valid_o !== 1'b1) begin errors++; $display("FAIL fli_refetch_miss: got %b want 1", mem_req_valid_o); end
        grant(); fill(32'h0000_03F0);
    endtask

    task automatic test_flush_mid_refill();
        issue(32'h0000_1234);
        grant();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL flr_busy_pend: got %b want 1", busy_o); end
        checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL flr_ready_pend: got %b want 0", req_ready_o); end
        fill(32'h0000_1230);
        checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL flr_rsp_valid: got %b want 1", rsp_valid_o); end
        checks++; if (rsp_inst_o !== 32'hC0DE_1234) begin errors++; $display("FAIL flr_rsp_inst: got %h want C0DE1234", rsp_inst_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL flr_busy_flush: got %b want 1", busy_o); end
        checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL flr_ready_flush: got %b want 0", req_ready_o); end
        step();
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL flr_ready_back: got %b want 1", req_ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL flr_busy_done: got %b want 0", busy_o); end
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL flr_single_rsp: got %b want 0", rsp_valid_o); end
        issue(32'h0000_1234);
        checks++; if (mem_req_valid_o !== 1'b1) begin errors++; $display("FAIL flr_refetch_miss: got %b want 1", mem_req_valid_o); end
        grant(); fill(32'h0000_1230);
        checks++; if (rsp_inst_o !== 32'hC0DE_1234) begin errors++; $display("FAIL flr_refill_inst: got %h want C0DE1234", rsp_inst_o); end
    endtask

    task automatic test_reset_mid_refill();
        issue(32'h0000_0500);
        grant();
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b want 1", req_ready_o); end
        checks++; if (rsp_inst_o !== 32'h0) begin errors++; $display("FAIL rst_rsp_inst: got %h want 0", rsp_inst_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
        checks++; if (mem_req_addr_o !== 32'h0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", mem_req_addr_o); end
        step();
        step();
        rst_n = 1'b1;
        fill(32'h0000_0500);
        checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_late_rvalid: got %b want 0", rsp_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_late_busy: got %b want 0", busy_o); end
        issue(32'h0000_1234);
        checks++; if (mem_req_valid_o !== 1'b1) begin errors++; $display("FAIL rst_refetch_miss: got %b want 1", mem_req_valid_o); end
        grant(); fill(32'h0000_1230);
        checks++; if (rsp_inst_o !== 32'hC0DE_1234) begin errors++; $display("FAIL rst_refill_inst: got %h want C0DE1234", rsp_inst_o); end
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        rst_n           = 1'b0;
        req_valid_i     = 1'b0;
        req_addr_i      = '0;
        flush_i         = 1'b0;
        mem_req_ready_i = 1'b0;
        mem_rvalid_i    = 1'b0;
        mem_rdata_i     = '0;
        step();
        step();
        rst_n = 1'b1;
        test_reset();
        test_cold_miss();
        test_streaming();
        test_conflict();
        test_backpressure();
        test_flush_idle();
        test_flush_mid_refill();
        test_reset_mid_refill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
